// File: rtl/ysyx_23060208_mem_arbiter.sv
// Two-master (IFU/LSU) read-channel arbiter over a single memory read port, with a response watchdog.
// Define ARB_RR_EN to select round-robin arbitration; the default is fixed priority (LSU over IFU).
module ysyx_23060208_mem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16,
  parameter int CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  // IFU read channel
  input  logic [DATA_WIDTH-1:0] ifu_araddr,
  input  logic                  ifu_arvalid,
  output logic                  ifu_arready,
  output logic [DATA_WIDTH-1:0] ifu_rdata,
  output logic [1:0]            ifu_rresp,
  output logic                  ifu_rvalid,
  input  logic                  ifu_rready,
  // LSU read channel
  input  logic [DATA_WIDTH-1:0] lsu_araddr,
  input  logic                  lsu_arvalid,
  output logic                  lsu_arready,
  output logic [DATA_WIDTH-1:0] lsu_rdata,
  output logic [1:0]            lsu_rresp,
  output logic                  lsu_rvalid,
  input  logic                  lsu_rready,
  // memory read port
  output logic [DATA_WIDTH-1:0] mem_araddr,
  output logic                  mem_arvalid,
  input  logic                  mem_arready,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic [1:0]            mem_rresp,
  input  logic                  mem_rvalid,
  output logic                  mem_rready
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_AR_FWD = 2'd1,
    S_R_WAIT = 2'd2,
    S_TOUT   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic             OWN_IFU = 1'b0;
  localparam logic             OWN_LSU = 1'b1;

  state_t           r_state;
  logic             r_owner;
  logic             r_last_owner;
  logic [CNT_W-1:0] r_wd_cnt;

  logic                  w_any_req;
  logic                  w_grant;
  logic [DATA_WIDTH-1:0] w_own_araddr;
  logic                  w_own_arvalid;
  logic                  w_own_rready;
  logic                  w_ar_hs;
  logic                  w_r_hs;
  logic                  w_tout_ack;

  assign w_any_req = ifu_arvalid | lsu_arvalid;

`ifdef ARB_RR_EN
  // Contention goes to whoever did not complete the previous transaction.
  assign w_grant = (ifu_arvalid & lsu_arvalid) ? ~r_last_owner : lsu_arvalid;
`else
  logic w_unused_last_owner;
  assign w_grant             = lsu_arvalid ? OWN_LSU : OWN_IFU;
  assign w_unused_last_owner = r_last_owner;
`endif

  assign w_own_araddr  = (r_owner == OWN_LSU) ? lsu_araddr  : ifu_araddr;
  assign w_own_arvalid = (r_owner == OWN_LSU) ? lsu_arvalid : ifu_arvalid;
  assign w_own_rready  = (r_owner == OWN_LSU) ? lsu_rready  : ifu_rready;

  assign w_ar_hs    = (r_state == S_AR_FWD) & w_own_arvalid & mem_arready;
  assign w_r_hs     = (r_state == S_R_WAIT) & mem_rvalid & w_own_rready;
  assign w_tout_ack = (r_state == S_TOUT) & w_own_rready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_owner      <= OWN_IFU;
      r_last_owner <= OWN_IFU;
      r_wd_cnt     <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_owner <= w_grant;
            r_state <= S_AR_FWD;
          end
        end
        S_AR_FWD: begin
          if (w_ar_hs) begin
            r_wd_cnt <= '0;
            r_state  <= S_R_WAIT;
          end else if (!w_own_arvalid) begin
            r_state <= S_IDLE;
          end
        end
        S_R_WAIT: begin
          // A handshake on the expiry cycle still delivers the real data.
          if (w_r_hs) begin
            r_last_owner <= r_owner;
            r_state      <= S_IDLE;
          end else if (r_wd_cnt == WD_LAST) begin
            r_state <= S_TOUT;
          end else begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
          end
        end
        S_TOUT: begin
          if (w_tout_ack) begin
            r_last_owner <= r_owner;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    ifu_arready = 1'b0;
    ifu_rdata   = '0;
    ifu_rresp   = '0;
    ifu_rvalid  = 1'b0;
    lsu_arready = 1'b0;
    lsu_rdata   = '0;
    lsu_rresp   = '0;
    lsu_rvalid  = 1'b0;
    mem_araddr  = '0;
    mem_arvalid = 1'b0;
    mem_rready  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        mem_rready = 1'b1;
      end
      S_AR_FWD: begin
        mem_araddr  = w_own_araddr;
        mem_arvalid = w_own_arvalid;
        if (r_owner == OWN_LSU) lsu_arready = mem_arready;
        else                    ifu_arready = mem_arready;
      end
      S_R_WAIT: begin
        mem_rready = w_own_rready;
        if (r_owner == OWN_LSU) begin
          lsu_rvalid = mem_rvalid;
          lsu_rdata  = mem_rdata;
          lsu_rresp  = mem_rresp;
        end else begin
          ifu_rvalid = mem_rvalid;
          ifu_rdata  = mem_rdata;
          ifu_rresp  = mem_rresp;
        end
      end
      S_TOUT: begin
        mem_rready = 1'b1;
        if (r_owner == OWN_LSU) begin
          lsu_rvalid = 1'b1;
          lsu_rresp  = 2'b10;
        end else begin
          ifu_rvalid = 1'b1;
          ifu_rresp  = 2'b10;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ysyx_23060208_mem_arbiter.sv
// Directed bench for ysyx_23060208_mem_arbiter: per-cycle vector table plus timeout and arbitration sequences.
module tb_ysyx_23060208_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ifu_araddr, lsu_araddr, mem_araddr;
  logic        ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rready;
  logic        lsu_arvalid, lsu_arready, lsu_rvalid, lsu_rready;
  logic [31:0] ifu_rdata, lsu_rdata, mem_rdata;
  logic [1:0]  ifu_rresp, lsu_rresp, mem_rresp;
  logic        mem_arvalid, mem_arready, mem_rvalid, mem_rready;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ysyx_23060208_mem_arbiter #(.DATA_WIDTH(32), .TIMEOUT(16), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready),
    .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready),
    .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready),
    .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp), .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready),
    .mem_araddr(mem_araddr), .mem_arvalid(mem_arvalid), .mem_arready(mem_arready),
    .mem_rdata(mem_rdata), .mem_rresp(mem_rresp), .mem_rvalid(mem_rvalid), .mem_rready(mem_rready)
  );

  typedef struct {
    logic rst, iv; logic [31:0] ia; logic irr, lv; logic [31:0] la; logic lrr, mar, mrv;
    logic [31:0] mrd; logic [1:0] mrs;
    logic e_iar, e_irv; logic [31:0] e_ird; logic [1:0] e_irs;
    logic e_lar, e_lrv; logic [31:0] e_lrd; logic [1:0] e_lrs;
    logic [31:0] e_maa; logic e_mav, e_mrr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(logic rst_i, logic iv, logic [31:0] ia, logic irr, logic lv, logic [31:0] la,
                             logic lrr, logic mar, logic mrv, logic [31:0] mrd, logic [1:0] mrs,
                             logic e_iar, logic e_irv, logic [31:0] e_ird, logic [1:0] e_irs,
                             logic e_lar, logic e_lrv, logic [31:0] e_lrd, logic [1:0] e_lrs,
                             logic [31:0] e_maa, logic e_mav, logic e_mrr);
    vec_t r;
    r.rst = rst_i; r.iv = iv; r.ia = ia; r.irr = irr; r.lv = lv; r.la = la; r.lrr = lrr;
    r.mar = mar; r.mrv = mrv; r.mrd = mrd; r.mrs = mrs;
    r.e_iar = e_iar; r.e_irv = e_irv; r.e_ird = e_ird; r.e_irs = e_irs;
    r.e_lar = e_lar; r.e_lrv = e_lrv; r.e_lrd = e_lrd; r.e_lrs = e_lrs;
    r.e_maa = e_maa; r.e_mav = e_mav; r.e_mrr = e_mrr;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t x);
    rst = x.rst; ifu_arvalid = x.iv; ifu_araddr = x.ia; ifu_rready = x.irr;
    lsu_arvalid = x.lv; lsu_araddr = x.la; lsu_rready = x.lrr;
    mem_arready = x.mar; mem_rvalid = x.mrv; mem_rdata = x.mrd; mem_rresp = x.mrs;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] A0 = 32'h8000_0000, A1 = 32'h8000_1000, A2 = 32'h8000_2000;
  localparam logic [31:0] A40 = 32'h8000_0040, A80 = 32'h8000_0080, AA = 32'h8000_00A0;

  initial begin
    vec_t z;
    logic [31:0] exp_addr;
    logic        exp_lsu;

    z = v(1,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0,0,1);
    drive(z);
    next_cycle();
    next_cycle();

    // rst,iv,ia,irr,lv,la,lrr,mar,mrv,mrd,mrs | iar,irv,ird,irs,lar,lrv,lrd,lrs,maa,mav,mrr
    vecs.push_back(v(1,0,0,0,0,0,0,0,0,0,0,                0,0,0,0,0,0,0,0,0,0,1));
    // single IFU read, zero-wait memory
    vecs.push_back(v(0,1,A0,1,0,0,0,1,0,0,0,               0,0,0,0,0,0,0,0,0,0,1));
    vecs.push_back(v(0,1,A0,1,0,0,0,1,0,0,0,               1,0,0,0,0,0,0,0,A0,1,0));
    vecs.push_back(v(0,0,A0,1,0,0,0,1,1,32'h413,0,         0,1,32'h413,0,0,0,0,0,0,0,1));
    // simultaneous requests: LSU first, IFU after a bubble
    vecs.push_back(v(0,1,A0,1,1,A1,1,1,0,0,0,              0,0,0,0,0,0,0,0,0,0,1));
    vecs.push_back(v(0,1,A0,1,1,A1,1,1,0,0,0,              0,0,0,0,1,0,0,0,A1,1,0));
    vecs.push_back(v(0,1,A0,1,0,A1,1,1,1,32'hDEADBEEF,0,   0,0,0,0,0,1,32'hDEADBEEF,0,0,0,1));
    vecs.push_back(v(0,1,A0,1,0,0,1,1,0,0,0,               0,0,0,0,0,0,0,0,0,0,1));
    vecs.push_back(v(0,1,A0,1,0,0,1,1,0,0,0,               1,0,0,0,0,0,0,0,A0,1,0));
    vecs.push_back(v(0,0,A0,1,0,0,1,1,1,32'h1234,1,        0,1,32'h1234,1,0,0,0,0,0,0,1));
    // memory stalls AR for 3 cycles, then R stalled by IFU rready
    vecs.push_back(v(0,1,A40,1,0,0,0,0,0,0,0,              0,0,0,0,0,0,0,0,0,0,1));
    vecs.push_back(v(0,1,A40,1,0,0,0,0,0,0,0,              0,0,0,0,0,0,0,0,A40,1,0));
    vecs.push_back(v(0,1,A40,1,0,0,0,0,0,0,0,              0,0,0,0,0,0,0,0,A40,1,0));
    vecs.push_back(v(0,1,A40,1,0,0,0,0,0,0,0,              0,0,0,0,0,0,0,0,A40,1,0));
    vecs.push_back(v(0,1,A40,1,0,0,0,1,0,0,0,              1,0,0,0,0,0,0,0,A40,1,0));
    vecs.push_back(v(0,0,A40,0,0,0,0,0,1,32'h55,0,         0,1,32'h55,0,0,0,0,0,0,0,0));
    vecs.push_back(v(0,0,A40,1,0,0,0,0,1,32'h55,0,         0,1,32'h55,0,0,0,0,0,0,0,1));
    // reset during R_WAIT, stray response drained, fresh IFU read
    vecs.push_back(v(0,0,0,0,1,A2,1,1,0,0,0,               0,0,0,0,0,0,0,0,0,0,1));
    vecs.push_back(v(0,0,0,0,1,A2,1,1,0,0,0,               0,0,0,0,1,0,0,0,A2,1,0));
    vecs.push_back(v(0,0,0,0,0,A2,1,1,0,0,0,               0,0,0,0,0,0,0,0,0,0,1));
    vecs.push_back(v(1,0,0,0,0,A2,1,1,0,0,0,               0,0,0,0,0,0,0,0,0,0,1));
    vecs.push_back(v(0,0,0,0,0,0,1,1,1,32'h99,0,           0,0,0,0,0,0,0,0,0,0,1));
    vecs.push_back(v(0,1,A80,1,0,0,0,1,0,0,0,              0,0,0,0,0,0,0,0,0,0,1));
    vecs.push_back(v(0,1,A80,1,0,0,0,1,0,0,0,              1,0,0,0,0,0,0,0,A80,1,0));
    vecs.push_back(v(0,0,A80,1,0,0,0,1,1,32'h77,0,         0,1,32'h77,0,0,0,0,0,0,0,1));
    // LSU withdraws arvalid before the AR handshake
    vecs.push_back(v(0,0,0,0,1,AA,1,0,0,0,0,               0,0,0,0,0,0,0,0,0,0,1));
    vecs.push_back(v(0,0,0,0,0,AA,1,0,0,0,0,               0,0,0,0,0,0,0,0,AA,0,0));
    vecs.push_back(v(0,0,0,0,0,0,0,0,0,0,0,                0,0,0,0,0,0,0,0,0,0,1));

    foreach (vecs[i]) begin
      drive(vecs[i]);
      @(negedge clk);
      chk($sformatf("v%0d ifu_arready", i), 32'(ifu_arready), 32'(vecs[i].e_iar));
      chk($sformatf("v%0d ifu_rvalid", i),  32'(ifu_rvalid),  32'(vecs[i].e_irv));
      chk($sformatf("v%0d ifu_rdata", i),   ifu_rdata,        vecs[i].e_ird);
      chk($sformatf("v%0d ifu_rresp", i),   32'(ifu_rresp),   32'(vecs[i].e_irs));
      chk($sformatf("v%0d lsu_arready", i), 32'(lsu_arready), 32'(vecs[i].e_lar));
      chk($sformatf("v%0d lsu_rvalid", i),  32'(lsu_rvalid),  32'(vecs[i].e_lrv));
      chk($sformatf("v%0d lsu_rdata", i),   lsu_rdata,        vecs[i].e_lrd);
      chk($sformatf("v%0d lsu_rresp", i),   32'(lsu_rresp),   32'(vecs[i].e_lrs));
      chk($sformatf("v%0d mem_araddr", i),  mem_araddr,       vecs[i].e_maa);
      chk($sformatf("v%0d mem_arvalid", i), 32'(mem_arvalid), 32'(vecs[i].e_mav));
      chk($sformatf("v%0d mem_rready", i),  32'(mem_rready),  32'(vecs[i].e_mrr));
      next_cycle();
    end

    // Watchdog: memory never responds; 16 R_WAIT cycles then SLVERR
    drive(v(0,1,32'h8000_0100,0,0,0,0,1,0,0,0, 0,0,0,0,0,0,0,0,0,0,0));
    next_cycle();
    next_cycle();
    ifu_arvalid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk($sformatf("wd%0d ifu_rvalid", k), 32'(ifu_rvalid), 32'd0);
      chk($sformatf("wd%0d mem_rready", k), 32'(mem_rready), 32'd0);
      next_cycle();
    end
    for (int k = 0; k < 2; k++) begin
      if (k == 1) begin mem_rvalid = 1'b1; mem_rdata = 32'hBAD0_BAD0; end
      @(negedge clk);
      chk("tout ifu_rvalid", 32'(ifu_rvalid), 32'd1);
      chk("tout ifu_rresp",  32'(ifu_rresp),  32'd2);
      chk("tout ifu_rdata",  ifu_rdata,       32'd0);
      chk("tout mem_rready", 32'(mem_rready), 32'd1);
      chk("tout lsu_rvalid", 32'(lsu_rvalid), 32'd0);
      next_cycle();
    end
    ifu_rready = 1'b1;
    next_cycle();
    @(negedge clk);
    chk("post-tout ifu_rvalid", 32'(ifu_rvalid), 32'd0);
    chk("post-tout mem_rready", 32'(mem_rready), 32'd1);
    chk("post-tout lsu_rvalid", 32'(lsu_rvalid), 32'd0);
    next_cycle();

    // Handshake on the expiry cycle wins over the timeout
    drive(v(0,1,32'h8000_0200,1,0,0,0,1,0,0,0, 0,0,0,0,0,0,0,0,0,0,0));
    next_cycle();
    next_cycle();
    ifu_arvalid = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      chk($sformatf("edge%0d ifu_rvalid", k), 32'(ifu_rvalid), 32'd0);
      next_cycle();
    end
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_0001; mem_rresp = 2'b00;
    @(negedge clk);
    chk("edge ifu_rvalid", 32'(ifu_rvalid), 32'd1);
    chk("edge ifu_rdata",  ifu_rdata,       32'hCAFE_0001);
    chk("edge ifu_rresp",  32'(ifu_rresp),  32'd0);
    next_cycle();
    mem_rvalid = 1'b0;
    @(negedge clk);
    chk("edge idle ifu_rvalid", 32'(ifu_rvalid), 32'd0);
    next_cycle();
    @(negedge clk);
    chk("edge no-tout ifu_rvalid", 32'(ifu_rvalid), 32'd0);
    next_cycle();

    // Continuous contention over four transactions
    rst = 1'b1;
    next_cycle();
    drive(v(0,1,A0,1,1,A1,1,1,1,32'h4242,0, 0,0,0,0,0,0,0,0,0,0,0));
    for (int t = 0; t < 4; t++) begin
`ifdef ARB_RR_EN
      exp_lsu = (t % 2 == 0);
`else
      exp_lsu = 1'b1;
`endif
      exp_addr = exp_lsu ? A1 : A0;
      @(negedge clk);
      chk($sformatf("arb%0d idle mem_arvalid", t), 32'(mem_arvalid), 32'd0);
      next_cycle();
      @(negedge clk);
      chk($sformatf("arb%0d mem_araddr", t), mem_araddr, exp_addr);
      next_cycle();
      @(negedge clk);
      chk($sformatf("arb%0d lsu_rvalid", t), 32'(lsu_rvalid), 32'(exp_lsu));
      chk($sformatf("arb%0d ifu_rvalid", t), 32'(ifu_rvalid), 32'(!exp_lsu));
      next_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
